// File: rtl/bscan_arb_pkg.sv
// Shared types and helpers for the BSCAN indication arbiter: message field
// layout, FSM state encoding and the LEN clamp used at grant time.
package bscan_arb_pkg;

    localparam int LEN_LSB    = 0;
    localparam int LEN_W      = 16;
    localparam int PORTAL_LSB = 16;
    localparam int WORD_W     = 32;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    typedef struct packed {
        logic [LEN_W-1:0] cnt;
        logic             err;
    } len_chk_t;

    // A zero LEN still occupies one word on the pipe; oversize LEN is cut to
    // the buffer depth. Both are flagged so software can spot a bad serializer.
    function automatic len_chk_t clamp_len(input logic [LEN_W-1:0] len,
                                           input logic [LEN_W-1:0] max_words);
        len_chk_t r;
        if (len == 16'd0) begin
            r.cnt = 16'd1;
            r.err = 1'b1;
        end else if (len > max_words) begin
            r.cnt = max_words;
            r.err = 1'b1;
        end else begin
            r.cnt = len;
            r.err = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first set request at or after i_ptr
// (wrapping) and returns it as a one-hot grant.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_grant,
    output logic                 o_valid
);

    logic [2*N-1:0] w_req_dbl;
    logic [N-1:0]   w_rot;
    logic [N-1:0]   w_rot_gnt;
    logic [2*N-1:0] w_gnt_dbl;

    // Rotate so i_ptr sits at bit 0, isolate the lowest set bit, rotate back.
    assign w_req_dbl = {i_req, i_req} >> i_ptr;
    assign w_rot     = w_req_dbl[N-1:0];
    assign w_rot_gnt = w_rot & ((~w_rot) + {{(N-1){1'b0}}, 1'b1});
    assign w_gnt_dbl = {w_rot_gnt, w_rot_gnt} << i_ptr;
    assign o_grant   = w_gnt_dbl[2*N-1:N];
    assign o_valid   = |i_req;

endmodule

// File: rtl/bscan_indication_arbiter.sv
// Merges N_REQ indication serializers onto one 32-bit BSCAN pipe: one holding
// slot per requester, round-robin pick, message streamed low word first.
module bscan_indication_arbiter
    import bscan_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MSG_W     = 144,
    parameter int MAX_WORDS = 5
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic [N_REQ-1:0]       req_enq_ena,
    input  logic [N_REQ*MSG_W-1:0] req_enq_v,
    output logic [N_REQ-1:0]       req_enq_rdy,
    output logic                   out_enq_ena,
    output logic [WORD_W-1:0]      out_enq_v,
    output logic                   out_enq_last,
    input  logic                   out_enq_rdy,
    output logic                   err_len,
    output logic [15:0]            msg_count
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int BUF_W = MAX_WORDS * WORD_W;

    logic [N_REQ-1:0] r_full;
    logic [MSG_W-1:0] r_slot [N_REQ];
    state_t           r_state;
    state_t           w_state_nxt;
    logic [PTR_W-1:0] r_rr_ptr;
    logic [LEN_W-1:0] r_word_idx;
    logic [LEN_W-1:0] r_word_cnt;
    logic [BUF_W-1:0] r_buf;
    logic             r_err_len;
    logic [15:0]      r_msg_count;

    logic [N_REQ-1:0]  w_grant;
    logic              w_valid;
    logic              w_xfer;
    logic              w_last;
    logic              w_last_xfer;
    logic              w_arb_en;
    logic              w_fire;
    logic [PTR_W-1:0]  w_win_idx;
    logic [PTR_W-1:0]  w_ptr_nxt;
    logic [MSG_W-1:0]  w_win_msg;
    logic [WORD_W-1:0] w_word;
    len_chk_t          w_len_chk;

    rr_arbiter #(
        .N(N_REQ)
    ) u_rr_arbiter (
        .i_req   (r_full),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_valid (w_valid)
    );

    assign w_xfer      = (r_state == SEND) && out_enq_rdy;
    assign w_last      = (r_state == SEND) && (r_word_idx == (r_word_cnt - 16'd1));
    assign w_last_xfer = w_xfer && w_last;
    // Re-arbitrating on the final word lets the next message follow with no bubble.
    assign w_arb_en    = (r_state == IDLE) || w_last_xfer;
    assign w_fire      = w_arb_en && w_valid;
    assign w_ptr_nxt   = (w_win_idx == PTR_W'(N_REQ - 1)) ? {PTR_W{1'b0}}
                                                          : (w_win_idx + PTR_W'(1));
    assign w_len_chk   = clamp_len(w_win_msg[LEN_LSB +: LEN_W], LEN_W'(MAX_WORDS));

    // Winner index and slot contents from the one-hot grant
    always_comb begin
        w_win_idx = {PTR_W{1'b0}};
        w_win_msg = {MSG_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            w_win_idx = w_win_idx | ({PTR_W{w_grant[i]}} & PTR_W'(i));
            w_win_msg = w_win_msg | ({MSG_W{w_grant[i]}} & r_slot[i]);
        end
    end

    // Current output word selected from the message buffer
    always_comb begin
        w_word = {WORD_W{1'b0}};
        for (int w = 0; w < MAX_WORDS; w++) begin
            w_word = w_word | ({WORD_W{r_word_idx == LEN_W'(w)}} & r_buf[w*WORD_W +: WORD_W]);
        end
    end

    // Holding slots: fill on enqueue, drain on grant
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            r_full <= {N_REQ{1'b0}};
            for (int i = 0; i < N_REQ; i++) begin
                r_slot[i] <= {MSG_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_enq_ena[i]) begin
                    r_full[i] <= 1'b1;
                    r_slot[i] <= req_enq_v[i*MSG_W +: MSG_W];
                end else if (w_fire && w_grant[i]) begin
                    r_full[i] <= 1'b0;
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_state_nxt = SEND;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SEND: begin
                if (w_last_xfer) begin
                    w_state_nxt = w_valid ? SEND : IDLE;
                end else begin
                    w_state_nxt = SEND;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Message buffer, word pointer, round-robin pointer and status
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            r_rr_ptr    <= {PTR_W{1'b0}};
            r_word_idx  <= 16'd0;
            r_word_cnt  <= 16'd0;
            r_buf       <= {BUF_W{1'b0}};
            r_err_len   <= 1'b0;
            r_msg_count <= 16'd0;
        end else begin
            if (w_fire) begin
                r_rr_ptr   <= w_ptr_nxt;
                r_buf      <= BUF_W'(w_win_msg);
                r_word_cnt <= w_len_chk.cnt;
                r_word_idx <= 16'd0;
                r_err_len  <= r_err_len | w_len_chk.err;
            end else if (w_xfer) begin
                r_word_idx <= w_last ? 16'd0 : (r_word_idx + 16'd1);
            end
            if (w_last_xfer) begin
                r_msg_count <= r_msg_count + 16'd1;
            end
        end
    end

    assign req_enq_rdy  = ~r_full;
    assign out_enq_ena  = w_xfer;
    assign out_enq_v    = w_word;
    assign out_enq_last = w_last;
    assign err_len      = r_err_len;
    assign msg_count    = r_msg_count;

endmodule

// File: tb/tb_bscan_indication_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic compared against
// a queue-based message model of the arbiter.
module tb_bscan_indication_arbiter;

    localparam int N     = 4;
    localparam int MSG_W = 144;
    localparam int MAXW  = 5;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [N-1:0]       req_ena = '0;
    logic [N*MSG_W-1:0] req_v = '0;
    logic [N-1:0]       req_rdy;
    logic               o_ena;
    logic [31:0]        o_v;
    logic               o_last;
    logic               o_rdy = 1'b0;
    logic               err;
    logic [15:0]        cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bscan_indication_arbiter #(.N_REQ(N), .MSG_W(MSG_W), .MAX_WORDS(MAXW)) dut (
        .CLK(clk), .nRST(rst),
        .req_enq_ena(req_ena), .req_enq_v(req_v), .req_enq_rdy(req_rdy),
        .out_enq_ena(o_ena), .out_enq_v(o_v), .out_enq_last(o_last), .out_enq_rdy(o_rdy),
        .err_len(err), .msg_count(cnt)
    );

    // Reference model: pending slot contents plus the queue of words still owed.
    bit               m_full [N];
    logic [MSG_W-1:0] m_msg  [N];
    logic [31:0]      m_words[$];
    int               m_ptr;
    bit               m_err;
    logic [15:0]      m_count;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin m_full[i] = 0; m_msg[i] = '0; end
        m_words.delete();
        m_ptr = 0; m_err = 0; m_count = 16'd0;
    endtask

    function automatic int clamp(input int len);
        if (len == 0) return 1;
        if (len > MAXW) return MAXW;
        return len;
    endfunction

    function automatic logic [N-1:0] model_rdy();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = !m_full[i];
        return r;
    endfunction

    task automatic model_tick();
        bit arb, found;
        int w, len, n;
        logic [MAXW*32-1:0] ext;
        arb = (m_words.size() == 0) || (o_rdy && m_words.size() == 1);
        if (m_words.size() != 0 && o_rdy) begin
            void'(m_words.pop_front());
            if (m_words.size() == 0) m_count = m_count + 16'd1;
        end
        found = 0;
        if (arb) begin
            for (int k = 0; k < N; k++) begin
                w = (m_ptr + k) % N;
                if (!found && m_full[w]) begin
                    found = 1;
                    len = int'(m_msg[w][15:0]);
                    n = clamp(len);
                    if (len == 0 || len > MAXW) m_err = 1;
                    ext = (MAXW*32)'(m_msg[w]);
                    for (int j = 0; j < n; j++) m_words.push_back(ext[j*32 +: 32]);
                    m_full[w] = 0;
                    m_ptr = (w + 1) % N;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (req_ena[i]) begin
                m_full[i] = 1;
                m_msg[i] = req_v[i*MSG_W +: MSG_W];
            end
        end
    endtask

    function automatic logic [MSG_W-1:0] make_msg(input int portal, input int len);
        logic [MSG_W-1:0] m;
        m = MSG_W'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
        m[15:0]  = 16'(len);
        m[31:16] = 16'(portal);
        return m;
    endfunction

    task automatic send(input int i, input logic [MSG_W-1:0] msg);
        req_ena[i] = 1'b1;
        req_v[i*MSG_W +: MSG_W] = msg;
    endtask

    task automatic advance();
        @(posedge clk);
        model_tick();
        @(negedge clk);
        req_ena = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b1; req_ena = '0; req_v = '0; o_rdy = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        rst = 1'b1; o_rdy = 1'b1;
        #1;
        n_checks += 6;
        if (req_rdy !== 4'hF) begin n_fail++; $display("FAIL reset_rdy: got %h expected f", req_rdy); end
        if (o_ena !== 1'b0)   begin n_fail++; $display("FAIL reset_ena: got %b expected 0", o_ena); end
        if (o_v !== 32'h0)    begin n_fail++; $display("FAIL reset_v: got %h expected 0", o_v); end
        if (o_last !== 1'b0)  begin n_fail++; $display("FAIL reset_last: got %b expected 0", o_last); end
        if (err !== 1'b0)     begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        if (cnt !== 16'd0)    begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", cnt); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [MSG_W-1:0] msg;
        apply_reset();
        o_rdy = 1'b1;
        msg = '0;
        msg[31:0]  = 32'h0005_0002;
        msg[63:32] = 32'hDEAD_BEEF;
        send(0, msg);
        #1;
        n_checks++;
        if (req_rdy !== 4'hF) begin n_fail++; $display("FAIL single_rdy_t: got %h expected f", req_rdy); end
        advance(); #1;
        n_checks += 2;
        if (req_rdy !== 4'hE) begin n_fail++; $display("FAIL single_rdy_t1: got %h expected e", req_rdy); end
        if (o_ena !== 1'b0)   begin n_fail++; $display("FAIL single_ena_t1: got %b expected 0", o_ena); end
        advance(); #1;
        n_checks += 2;
        if (o_ena !== 1'b1 || o_v !== 32'h0005_0002 || o_last !== 1'b0) begin
            n_fail++; $display("FAIL single_w0: got ena=%b v=%h last=%b expected 1 00050002 0", o_ena, o_v, o_last);
        end
        if (req_rdy !== 4'hF) begin n_fail++; $display("FAIL single_rdy_t2: got %h expected f", req_rdy); end
        advance(); #1;
        n_checks++;
        if (o_ena !== 1'b1 || o_v !== 32'hDEAD_BEEF || o_last !== 1'b1) begin
            n_fail++; $display("FAIL single_w1: got ena=%b v=%h last=%b expected 1 deadbeef 1", o_ena, o_v, o_last);
        end
        advance(); #1;
        n_checks += 2;
        if (o_ena !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %b expected 0", o_ena); end
        if (cnt !== 16'd1)  begin n_fail++; $display("FAIL single_cnt: got %0d expected 1", cnt); end
    endtask

    task automatic test_all_four();
        int order[$];
        int run, best;
        bit in_msg, busy;
        apply_reset();
        o_rdy = 1'b1;
        for (int i = 0; i < N; i++) send(i, make_msg(i, 2));
        run = 0; best = 0; in_msg = 0;
        for (int c = 0; c < 14; c++) begin
            #1;
            busy = (m_words.size() != 0);
            n_checks += 3;
            if (o_ena !== (busy && o_rdy)) begin n_fail++; $display("FAIL all4_ena: got %b expected %b", o_ena, busy && o_rdy); end
            if (req_rdy !== model_rdy()) begin n_fail++; $display("FAIL all4_rdy: got %h expected %h", req_rdy, model_rdy()); end
            if (cnt !== m_count) begin n_fail++; $display("FAIL all4_cnt: got %0d expected %0d", cnt, m_count); end
            if (busy) begin
                n_checks++;
                if (o_v !== m_words[0] || o_last !== (m_words.size() == 1)) begin
                    n_fail++; $display("FAIL all4_word: got %h/%b expected %h/%b", o_v, o_last, m_words[0], m_words.size() == 1);
                end
            end
            if (o_ena) begin
                if (!in_msg) order.push_back(int'(o_v[31:16]));
                in_msg = !o_last;
                run++;
                if (run > best) best = run;
            end else begin
                run = 0;
            end
            advance();
        end
        n_checks += 3;
        if (order.size() != 4 || order[0] != 0 || order[1] != 1 || order[2] != 2 || order[3] != 3) begin
            n_fail++; $display("FAIL all4_order: got %p expected '{0,1,2,3}", order);
        end
        if (best != 8) begin n_fail++; $display("FAIL all4_burst: got %0d expected 8", best); end
        if (cnt !== 16'd4) begin n_fail++; $display("FAIL all4_total: got %0d expected 4", cnt); end
    endtask

    task automatic test_backpressure();
        bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int xfers, lasts, last_at;
        bit stall_prev, busy;
        logic [31:0] prev_v;
        apply_reset();
        o_rdy = 1'b1;
        send(3, make_msg(3, 4));
        xfers = 0; lasts = 0; last_at = -1; stall_prev = 0; prev_v = '0;
        for (int c = 0; c < 16; c++) begin
            o_rdy = (c >= 2) ? pat[(c-2) % 4] : 1'b1;
            #1;
            busy = (m_words.size() != 0);
            n_checks += 2;
            if (o_ena !== (busy && o_rdy)) begin n_fail++; $display("FAIL bp_ena: got %b expected %b", o_ena, busy && o_rdy); end
            if (req_rdy !== model_rdy()) begin n_fail++; $display("FAIL bp_rdy: got %h expected %h", req_rdy, model_rdy()); end
            if (busy) begin
                n_checks++;
                if (o_v !== m_words[0] || o_last !== (m_words.size() == 1)) begin
                    n_fail++; $display("FAIL bp_word: got %h/%b expected %h/%b", o_v, o_last, m_words[0], m_words.size() == 1);
                end
            end
            if (stall_prev && busy) begin
                n_checks++;
                if (o_v !== prev_v) begin n_fail++; $display("FAIL bp_hold: got %h expected %h", o_v, prev_v); end
            end
            if (o_ena) begin
                xfers++;
                if (o_last) begin lasts++; last_at = xfers; end
            end
            stall_prev = busy && !o_rdy;
            prev_v = o_v;
            advance();
        end
        n_checks += 2;
        if (xfers != 4) begin n_fail++; $display("FAIL bp_xfers: got %0d expected 4", xfers); end
        if (lasts != 1 || last_at != 4) begin n_fail++; $display("FAIL bp_last: got %0d at %0d expected 1 at 4", lasts, last_at); end
    endtask

    task automatic test_len_err();
        int lens[$];
        bit in_msg;
        apply_reset();
        o_rdy = 1'b1;
        send(0, make_msg(0, 0));
        send(1, make_msg(1, 9));
        in_msg = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (o_ena) begin
                if (!in_msg) lens.push_back(0);
                lens[lens.size()-1] = lens[lens.size()-1] + 1;
                in_msg = !o_last;
            end
            advance();
        end
        n_checks += 2;
        if (lens.size() != 2 || lens[0] != 1 || lens[1] != 5) begin
            n_fail++; $display("FAIL len_clamp: got %p expected '{1,5}", lens);
        end
        if (err !== 1'b1) begin n_fail++; $display("FAIL len_err_set: got %b expected 1", err); end
        send(2, make_msg(2, 3));
        repeat (6) advance();
        #1;
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL len_err_sticky: got %b expected 1", err); end
        apply_reset();
        #1;
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL len_err_clear: got %b expected 0", err); end
    endtask

    task automatic test_fairness();
        int fill_c, pos2, after;
        bit in_msg;
        apply_reset();
        o_rdy = 1'b1;
        fill_c = 4; pos2 = -1; after = 0; in_msg = 0;
        for (int c = 0; c < 30; c++) begin
            if (!m_full[1]) send(1, make_msg(1, 1));
            if (c == fill_c) send(2, make_msg(2, 1));
            #1;
            if (o_ena) begin
                if (!in_msg && c >= fill_c + 2) begin
                    after++;
                    if (pos2 < 0 && o_v[31:16] == 16'd2) pos2 = after;
                end
                in_msg = !o_last;
            end
            advance();
        end
        n_checks++;
        if (pos2 < 1 || pos2 > 2) begin n_fail++; $display("FAIL fairness: got grant position %0d expected 1..2", pos2); end
    endtask

    task automatic test_random();
        bit busy;
        apply_reset();
        for (int c = 0; c < 440; c++) begin
            o_rdy = (c >= 400) ? 1'b1 : ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (c < 400 && !m_full[i] && $urandom_range(0, 2) == 0)
                    send(i, make_msg(i, $urandom_range(0, 7)));
            end
            #1;
            busy = (m_words.size() != 0);
            n_checks += 3;
            if (o_ena !== (busy && o_rdy)) begin n_fail++; $display("FAIL rnd_ena: cyc %0d got %b expected %b", c, o_ena, busy && o_rdy); end
            if (req_rdy !== model_rdy()) begin n_fail++; $display("FAIL rnd_rdy: cyc %0d got %h expected %h", c, req_rdy, model_rdy()); end
            if (err !== m_err || cnt !== m_count) begin
                n_fail++; $display("FAIL rnd_status: cyc %0d got err=%b cnt=%0d expected err=%b cnt=%0d", c, err, cnt, m_err, m_count);
            end
            if (busy) begin
                n_checks++;
                if (o_v !== m_words[0] || o_last !== (m_words.size() == 1)) begin
                    n_fail++; $display("FAIL rnd_word: cyc %0d got %h/%b expected %h/%b", c, o_v, o_last, m_words[0], m_words.size() == 1);
                end
            end
            advance();
        end
        n_checks++;
        if (m_words.size() != 0 || o_ena !== 1'b0) begin
            n_fail++; $display("FAIL rnd_drain: got %0d words pending, ena=%b expected 0,0", m_words.size(), o_ena);
        end
    endtask

    task automatic test_reset_mid();
        int xfers;
        apply_reset();
        o_rdy = 1'b1;
        send(0, make_msg(0, 4));
        advance();
        send(1, make_msg(1, 2));
        xfers = 0;
        for (int c = 0; c < 10 && xfers < 2; c++) begin
            #1;
            if (o_ena) xfers++;
            advance();
        end
        n_checks++;
        if (xfers != 2) begin n_fail++; $display("FAIL mid_setup: got %0d transfers expected 2", xfers); end
        rst = 1'b1;
        #1;
        n_checks += 3;
        if (o_ena !== 1'b0 || o_v !== 32'h0 || o_last !== 1'b0) begin
            n_fail++; $display("FAIL mid_out: got ena=%b v=%h last=%b expected 0 0 0", o_ena, o_v, o_last);
        end
        if (req_rdy !== 4'hF) begin n_fail++; $display("FAIL mid_rdy: got %h expected f", req_rdy); end
        if (cnt !== 16'd0) begin n_fail++; $display("FAIL mid_cnt: got %0d expected 0", cnt); end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            n_checks++;
            if (o_ena !== 1'b0) begin n_fail++; $display("FAIL mid_stale: cyc %0d got ena=%b expected 0", c, o_ena); end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_backpressure();
        test_len_err();
        test_fairness();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
